// File: rtl/m_capture_if.sv
// Capture sequencer bus: sample/trigger inputs, RAM write port, host status.
// M_CAPTURE_AUTO_TRIG_EN adds auto_tmo_i / auto_fired_o.
interface m_capture_if #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 10
`ifdef M_CAPTURE_AUTO_TRIG_EN
   ,parameter int TIMEOUT_W = 16
`endif
);
    logic [WIDTH-1:0]  in_i;
    logic              trig_pos_i;
    logic              trig_neg_i;
    logic              edge_sel_i;
    logic              arm_i;
    logic              force_i;
    logic [ADDR_W-1:0] pre_len_i;
    logic [ADDR_W-1:0] post_len_i;
    logic              wr_en_o;
    logic [ADDR_W-1:0] wr_addr_o;
    logic [WIDTH-1:0]  wr_data_o;
    logic [ADDR_W-1:0] trig_addr_o;
    logic              busy_o;
    logic              done_o;
`ifdef M_CAPTURE_AUTO_TRIG_EN
    logic [TIMEOUT_W-1:0] auto_tmo_i;
    logic                 auto_fired_o;
`endif

    modport slave (
        input  in_i, trig_pos_i, trig_neg_i, edge_sel_i, arm_i, force_i,
        input  pre_len_i, post_len_i,
`ifdef M_CAPTURE_AUTO_TRIG_EN
        input  auto_tmo_i,
        output auto_fired_o,
`endif
        output wr_en_o, wr_addr_o, wr_data_o, trig_addr_o, busy_o, done_o
    );

    modport master (
        output in_i, trig_pos_i, trig_neg_i, edge_sel_i, arm_i, force_i,
        output pre_len_i, post_len_i,
`ifdef M_CAPTURE_AUTO_TRIG_EN
        output auto_tmo_i,
        input  auto_fired_o,
`endif
        input  wr_en_o, wr_addr_o, wr_data_o, trig_addr_o, busy_o, done_o
    );
endinterface

// File: rtl/m_capture.sv
// Scope capture sequencer: pre-trigger history, trigger wait, post-trigger fill.
// Optional auto-trigger timeout enabled by M_CAPTURE_AUTO_TRIG_EN.
module m_capture #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 10
`ifdef M_CAPTURE_AUTO_TRIG_EN
   ,parameter int TIMEOUT_W = 16
`endif
) (
    input  logic        clk,
    input  logic        rst,
    m_capture_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_WAIT, S_POST, S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic              arm_q;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] pre_q, pre_d;
    logic [ADDR_W-1:0] post_q, post_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [WIDTH-1:0]  wr_data_q, wr_data_d;
    logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              arm_rise, trig, take, write;
`ifdef M_CAPTURE_AUTO_TRIG_EN
    logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
    logic                 fired_q, fired_d;
    logic                 auto_hit;
`endif

    assign arm_rise = bus.arm_i & ~arm_q;
    assign trig = (bus.edge_sel_i ? bus.trig_neg_i : bus.trig_pos_i)
                | bus.force_i;
`ifdef M_CAPTURE_AUTO_TRIG_EN
    assign auto_hit = (bus.auto_tmo_i != '0) && (tmo_q == bus.auto_tmo_i);
    assign take     = trig | auto_hit;
`else
    assign take     = trig;
`endif

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        pre_d       = pre_q;
        post_d      = post_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        trig_addr_d = trig_addr_q;
        write       = 1'b0;
`ifdef M_CAPTURE_AUTO_TRIG_EN
        tmo_d       = tmo_q;
        fired_d     = fired_q;
`endif
        unique case (state_q)
            S_IDLE: if (arm_rise) begin
                pre_d   = bus.pre_len_i;
                post_d  = bus.post_len_i;
                cnt_d   = '0;
                state_d = (bus.pre_len_i != '0) ? S_PRE : S_WAIT;
`ifdef M_CAPTURE_AUTO_TRIG_EN
                tmo_d   = '0;
                fired_d = 1'b0;
`endif
            end
            S_PRE: if (!bus.arm_i) begin
                state_d = S_IDLE;
            end else begin
                write = 1'b1;
                cnt_d = cnt_q + ADDR_W'(1);
                if (cnt_d == pre_q) begin
                    state_d = S_WAIT;
`ifdef M_CAPTURE_AUTO_TRIG_EN
                    tmo_d   = '0;
`endif
                end
            end
            S_WAIT: if (!bus.arm_i) begin
                state_d = S_IDLE;
            end else begin
                write = 1'b1;
`ifdef M_CAPTURE_AUTO_TRIG_EN
                tmo_d = tmo_q + TIMEOUT_W'(1);
                if (auto_hit && !trig) fired_d = 1'b1;
`endif
                if (take) begin
                    trig_addr_d = ptr_q;
                    cnt_d       = '0;
                    state_d     = (post_q == '0) ? S_DONE : S_POST;
                end
            end
            S_POST: if (!bus.arm_i) begin
                state_d = S_IDLE;
            end else begin
                write = 1'b1;
                cnt_d = cnt_q + ADDR_W'(1);
                if (cnt_d == post_q) state_d = S_DONE;
            end
            S_DONE: if (!bus.arm_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // ptr_q is the next free RAM slot; it survives across captures
        if (write) begin
            wr_en_d   = 1'b1;
            wr_addr_d = ptr_q;
            wr_data_d = bus.in_i;
            ptr_d     = ptr_q + ADDR_W'(1);
        end
        busy_d = (state_d == S_PRE) || (state_d == S_WAIT)
              || (state_d == S_POST);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            arm_q       <= 1'b0;
            ptr_q       <= '0;
            cnt_q       <= '0;
            pre_q       <= '0;
            post_q      <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            trig_addr_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef M_CAPTURE_AUTO_TRIG_EN
            tmo_q       <= '0;
            fired_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            arm_q       <= bus.arm_i;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            pre_q       <= pre_d;
            post_q      <= post_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            trig_addr_q <= trig_addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef M_CAPTURE_AUTO_TRIG_EN
            tmo_q       <= tmo_d;
            fired_q     <= fired_d;
`endif
        end
    end

    assign bus.wr_en_o     = wr_en_q;
    assign bus.wr_addr_o   = wr_addr_q;
    assign bus.wr_data_o   = wr_data_q;
    assign bus.trig_addr_o = trig_addr_q;
    assign bus.busy_o      = busy_q;
    assign bus.done_o      = done_q;
`ifdef M_CAPTURE_AUTO_TRIG_EN
    assign bus.auto_fired_o = fired_q;
`endif
endmodule

// File: tb/tb_m_capture.sv
// Directed testbench for m_capture (ADDR_W=4, WIDTH=8).
// Auto-trigger scenario is built only with M_CAPTURE_AUTO_TRIG_EN.
module tb_m_capture;
    localparam int WIDTH  = 8;
    localparam int ADDR_W = 4;

    logic clk;
    logic rst;
    int   n_tot;
    int   n_pass;
    logic [31:0] got, exp;

`ifdef M_CAPTURE_AUTO_TRIG_EN
    m_capture_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .TIMEOUT_W(16)) b ();
    m_capture #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .TIMEOUT_W(16)) dut (
        .clk(clk), .rst(rst), .bus(b.slave));
`else
    m_capture_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) b ();
    m_capture #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .bus(b.slave));
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // got/exp packing: {wr_en, busy, done, trig_addr[4], wr_addr[4], wr_data[8]}
    task automatic test_reset();
        rst = 1'b1;
        b.in_i = '0; b.trig_pos_i = 0; b.trig_neg_i = 0; b.edge_sel_i = 0;
        b.arm_i = 0; b.force_i = 0; b.pre_len_i = '0; b.post_len_i = '0;
`ifdef M_CAPTURE_AUTO_TRIG_EN
        b.auto_tmo_i = '0;
`endif
        #12;
        got = {b.wr_en_o, b.busy_o, b.done_o, b.trig_addr_o, b.wr_addr_o, b.wr_data_o};
        exp = '0;
        n_tot++;
        if (got !== exp) $display("FAIL reset_outputs got=%h exp=%h", got, exp);
        else n_pass++;
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        b.arm_i = 1; b.pre_len_i = 4; b.post_len_i = 3; b.edge_sel_i = 0;
        step();
        got = {b.wr_en_o, b.busy_o, b.done_o};
        n_tot++;
        if (got !== 32'b010) $display("FAIL basic_armed got=%h exp=%h", got, 32'b010);
        else n_pass++;
        b.pre_len_i = 9; b.post_len_i = 9;
        for (int i = 0; i < 4; i++) begin
            b.in_i = 8'(8'h10 + i);
            step();
            got = {b.wr_en_o, b.busy_o, b.done_o, b.wr_addr_o, b.wr_data_o};
            exp = {1'b1, 1'b1, 1'b0, 4'(i), 8'(8'h10 + i)};
            n_tot++;
            if (got !== exp) $display("FAIL basic_pre%0d got=%h exp=%h", i, got, exp);
            else n_pass++;
        end
        b.in_i = 8'h20;
        step();
        got = {b.wr_en_o, b.busy_o, b.trig_addr_o, b.wr_addr_o, b.wr_data_o};
        exp = {1'b1, 1'b1, 4'd0, 4'd4, 8'h20};
        n_tot++;
        if (got !== exp) $display("FAIL basic_wait1 got=%h exp=%h", got, exp);
        else n_pass++;
        b.in_i = 8'h21; b.trig_pos_i = 1;
        step();
        b.trig_pos_i = 0;
        got = {b.wr_en_o, b.busy_o, b.trig_addr_o, b.wr_addr_o, b.wr_data_o};
        exp = {1'b1, 1'b1, 4'd5, 4'd5, 8'h21};
        n_tot++;
        if (got !== exp) $display("FAIL basic_trigger got=%h exp=%h", got, exp);
        else n_pass++;
        for (int j = 0; j < 3; j++) begin
            b.in_i = 8'(8'h30 + j);
            step();
            got = {b.wr_en_o, b.busy_o, b.done_o, b.trig_addr_o, b.wr_addr_o, b.wr_data_o};
            exp = {1'b1, (j != 2), (j == 2), 4'd5, 4'(6 + j), 8'(8'h30 + j)};
            n_tot++;
            if (got !== exp) $display("FAIL basic_post%0d got=%h exp=%h", j, got, exp);
            else n_pass++;
        end
        for (int k = 0; k < 4; k++) begin
            step();
            got = {b.wr_en_o, b.busy_o, b.done_o, b.trig_addr_o};
            exp = {1'b0, 1'b0, 1'b1, 4'd5};
            n_tot++;
            if (got !== exp) $display("FAIL basic_done_hold%0d got=%h exp=%h", k, got, exp);
            else n_pass++;
        end
        b.arm_i = 0;
        step();
        got = {b.wr_en_o, b.busy_o, b.done_o};
        n_tot++;
        if (got !== 32'b000) $display("FAIL basic_idle got=%h exp=%h", got, 32'b000);
        else n_pass++;
    endtask

    task automatic test_edge_sel();
        b.edge_sel_i = 1; b.pre_len_i = 2; b.post_len_i = 1; b.arm_i = 1;
        step();
        b.trig_pos_i = 1; b.in_i = 8'h40;
        step();
        b.trig_pos_i = 0; b.in_i = 8'h41;
        step();
        got = {b.wr_en_o, b.busy_o, b.wr_addr_o, b.wr_data_o};
        exp = {1'b1, 1'b1, 4'd10, 8'h41};
        n_tot++;
        if (got !== exp) $display("FAIL esel_pre got=%h exp=%h", got, exp);
        else n_pass++;
        b.trig_pos_i = 1; b.in_i = 8'h42;
        step();
        got = {b.busy_o, b.trig_addr_o, b.wr_addr_o};
        exp = {1'b1, 4'd5, 4'd11};
        n_tot++;
        if (got !== exp) $display("FAIL esel_pos_ignored got=%h exp=%h", got, exp);
        else n_pass++;
        b.trig_neg_i = 1; b.in_i = 8'h43;
        step();
        b.trig_pos_i = 0; b.trig_neg_i = 0; b.in_i = 8'h44;
        got = {b.busy_o, b.trig_addr_o, b.wr_addr_o, b.wr_data_o};
        exp = {1'b1, 4'd12, 4'd12, 8'h43};
        n_tot++;
        if (got !== exp) $display("FAIL esel_neg_trig got=%h exp=%h", got, exp);
        else n_pass++;
        step();
        got = {b.wr_en_o, b.busy_o, b.done_o, b.wr_addr_o, b.wr_data_o};
        exp = {1'b1, 1'b0, 1'b1, 4'd13, 8'h44};
        n_tot++;
        if (got !== exp) $display("FAIL esel_done got=%h exp=%h", got, exp);
        else n_pass++;
        b.arm_i = 0; b.edge_sel_i = 0;
        step();
    endtask

    task automatic test_wrap();
        b.pre_len_i = 3; b.post_len_i = 2; b.arm_i = 1;
        step();
        for (int i = 0; i < 3; i++) begin
            b.in_i = 8'(8'h50 + i);
            step();
            got = {b.wr_en_o, b.wr_addr_o, b.wr_data_o};
            exp = {1'b1, (i == 0) ? 4'd14 : (i == 1) ? 4'd15 : 4'd0, 8'(8'h50 + i)};
            n_tot++;
            if (got !== exp) $display("FAIL wrap_pre%0d got=%h exp=%h", i, got, exp);
            else n_pass++;
        end
        b.trig_pos_i = 1;
        step();
        b.trig_pos_i = 0;
        got = {b.trig_addr_o, b.wr_addr_o};
        exp = {4'd1, 4'd1};
        n_tot++;
        if (got !== exp) $display("FAIL wrap_trig got=%h exp=%h", got, exp);
        else n_pass++;
        step();
        step();
        got = {b.wr_en_o, b.done_o, b.trig_addr_o, b.wr_addr_o};
        exp = {1'b1, 1'b1, 4'd1, 4'd3};
        n_tot++;
        if (got !== exp) $display("FAIL wrap_post got=%h exp=%h", got, exp);
        else n_pass++;
        b.arm_i = 0;
        step();
    endtask

    task automatic test_zero_len();
        b.pre_len_i = 0; b.post_len_i = 0; b.arm_i = 1;
        step();
        got = {b.wr_en_o, b.busy_o, b.done_o};
        n_tot++;
        if (got !== 32'b010) $display("FAIL zero_wait got=%h exp=%h", got, 32'b010);
        else n_pass++;
        b.force_i = 1; b.in_i = 8'h60;
        step();
        b.force_i = 0;
        got = {b.wr_en_o, b.busy_o, b.done_o, b.trig_addr_o, b.wr_addr_o, b.wr_data_o};
        exp = {1'b1, 1'b0, 1'b1, 4'd4, 4'd4, 8'h60};
        n_tot++;
        if (got !== exp) $display("FAIL zero_single_write got=%h exp=%h", got, exp);
        else n_pass++;
        step();
        got = {b.wr_en_o, b.done_o};
        n_tot++;
        if (got !== 32'b01) $display("FAIL zero_done got=%h exp=%h", got, 32'b01);
        else n_pass++;
        b.arm_i = 0;
        step();
        b.pre_len_i = 1; b.post_len_i = 1; b.arm_i = 1;
        step();
        step();
        b.force_i = 1;
        step();
        b.force_i = 0;
        step();
        got = {b.wr_en_o, b.done_o, b.trig_addr_o, b.wr_addr_o};
        exp = {1'b1, 1'b1, 4'd6, 4'd7};
        n_tot++;
        if (got !== exp) $display("FAIL rearm_capture got=%h exp=%h", got, exp);
        else n_pass++;
        b.arm_i = 0;
        step();
    endtask

    task automatic test_abort();
        b.pre_len_i = 1; b.post_len_i = 3; b.arm_i = 1;
        step();
        step();
        b.force_i = 1;
        step();
        b.force_i = 0;
        step();
        b.arm_i = 0;
        step();
        got = {b.wr_en_o, b.busy_o, b.done_o, b.trig_addr_o, b.wr_addr_o};
        exp = {1'b0, 1'b0, 1'b0, 4'd9, 4'd10};
        n_tot++;
        if (got !== exp) $display("FAIL abort_post got=%h exp=%h", got, exp);
        else n_pass++;
        b.pre_len_i = 0; b.post_len_i = 0; b.arm_i = 1;
        step();
        b.arm_i = 0; b.force_i = 1;
        step();
        b.force_i = 0;
        got = {b.wr_en_o, b.busy_o, b.done_o, b.trig_addr_o};
        exp = {1'b0, 1'b0, 1'b0, 4'd9};
        n_tot++;
        if (got !== exp) $display("FAIL abort_beats_trig got=%h exp=%h", got, exp);
        else n_pass++;
        b.arm_i = 1; b.in_i = 8'h70;
        step();
        step();
        got = {b.wr_en_o, b.busy_o, b.wr_addr_o};
        exp = {1'b1, 1'b1, 4'd11};
        n_tot++;
        if (got !== exp) $display("FAIL rst_pre_wait got=%h exp=%h", got, exp);
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        got = {b.wr_en_o, b.busy_o, b.done_o, b.trig_addr_o, b.wr_addr_o, b.wr_data_o};
        exp = '0;
        n_tot++;
        if (got !== exp) $display("FAIL async_reset got=%h exp=%h", got, exp);
        else n_pass++;
        b.arm_i = 0;
        #4 rst = 1'b0;
        step();
    endtask

`ifdef M_CAPTURE_AUTO_TRIG_EN
    task automatic test_auto();
        b.pre_len_i = 0; b.post_len_i = 0; b.auto_tmo_i = 5; b.arm_i = 1;
        step();
        for (int i = 0; i < 5; i++) step();
        got = {b.wr_en_o, b.done_o, b.auto_fired_o, b.wr_addr_o};
        exp = {1'b1, 1'b0, 1'b0, 4'd4};
        n_tot++;
        if (got !== exp) $display("FAIL auto_before got=%h exp=%h", got, exp);
        else n_pass++;
        step();
        got = {b.wr_en_o, b.done_o, b.auto_fired_o, b.trig_addr_o};
        exp = {1'b1, 1'b1, 1'b1, 4'd5};
        n_tot++;
        if (got !== exp) $display("FAIL auto_fire got=%h exp=%h", got, exp);
        else n_pass++;
        b.arm_i = 0;
        step();
        b.auto_tmo_i = 0; b.arm_i = 1;
        step();
        got = {b.busy_o, b.auto_fired_o};
        n_tot++;
        if (got !== 32'b10) $display("FAIL auto_clear got=%h exp=%h", got, 32'b10);
        else n_pass++;
        for (int i = 0; i < 100; i++) step();
        got = {b.busy_o, b.done_o, b.auto_fired_o};
        n_tot++;
        if (got !== 32'b100) $display("FAIL auto_disabled got=%h exp=%h", got, 32'b100);
        else n_pass++;
        b.arm_i = 0;
        step();
    endtask
`endif

    initial begin
        n_tot = 0;
        n_pass = 0;
        test_reset();
        test_basic();
        test_edge_sel();
        test_wrap();
        test_zero_len();
        test_abort();
`ifdef M_CAPTURE_AUTO_TRIG_EN
        test_auto();
`endif
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/m_capture.md
Name: m_capture

Overview:
- Capture sequencer and trigger consumer for the scope acquisition path.
- Takes the sample stream together with the positive/negative transition flags from the delta comparator.
- Writes samples into a circular sample RAM: first a pre-trigger history, then it waits for a trigger, then it writes a fixed number of post-trigger samples.
- Reports the RAM address where the trigger occurred and a done/arm handshake to the host-side readout logic.

Parameters:
- WIDTH, 8, sample width in bits.
- ADDR_W, 10, sample RAM address width; depth = 2^ADDR_W.
- TIMEOUT_W, 16, auto-trigger timeout counter width (used only with the optional feature).

Ports:
- clk  in  1  sample clock.
- rst  in  1  asynchronous reset, active-high.
- in  in  WIDTH  sample, aligned with trig_pos/trig_neg.
- trig_pos  in  1  positive transition flag.
- trig_neg  in  1  negative transition flag.
- edge_sel  in  1  0 = trigger on trig_pos, 1 = trigger on trig_neg.
- arm  in  1  level; rising edge starts capture; low aborts or acknowledges.
- force  in  1  software trigger; honoured only in WAIT.
- pre_len  in  ADDR_W  pre-trigger samples, range 0..2^ADDR_W-1.
- post_len  in  ADDR_W  post-trigger samples after the trigger sample.
- wr_en  out  1  RAM write strobe.
- wr_addr  out  ADDR_W  RAM write address.
- wr_data  out  WIDTH  RAM write data.
- trig_addr  out  ADDR_W  address of the trigger sample.
- busy  out  1  high in PRE, WAIT and POST.
- done  out  1  high in DONE.

Behaviour:
- Reset values: state IDLE; wr_en=0, wr_addr=0, wr_data=0, trig_addr=0, busy=0, done=0. Internal counters 0; arm edge register 0.
- All outputs are registered. A sample presented at cycle N is written at cycle N+1: wr_data = in(N), wr_en=1.
- Every write advances wr_addr by 1 on the following write, modulo 2^ADDR_W; it wraps 2^ADDR_W-1 -> 0. wr_addr is not cleared between captures.
- pre_len and post_len are latched on the arm rising edge; later changes are ignored until the next arm edge.
- IDLE:
  - arm rising edge (arm=1 while the registered arm=0) -> PRE if pre_len>0, else WAIT.
  - wr_en=0.
- PRE:
  - Writes one sample per cycle and counts to the latched pre_len.
  - Triggers and force are ignored.
  - After pre_len writes -> WAIT.
- WAIT:
  - Writes one sample per cycle.
  - A trigger is the selected flag OR force.
  - On a trigger at cycle N: trig_addr <= the address that in(N) is written to; go to POST, or DONE if post_len=0.
- POST:
  - Writes exactly post_len further samples after the trigger sample.
  - Then DONE; the last write occurs in the cycle the state changes to DONE.
- DONE:
  - wr_en=0; done=1; trig_addr is held.
  - arm=0 -> IDLE.
  - arm held high never restarts the block; a new rising edge is required.
- Abort: arm=0 in PRE, WAIT or POST -> IDLE on the next cycle; trig_addr keeps its old value.
- Simultaneous events:
  - arm falling together with a trigger: the abort wins.
  - trig_pos and trig_neg both high: only edge_sel matters.
- Reset mid-capture returns to IDLE immediately (asynchronous).
- busy=1 exactly in PRE, WAIT and POST.

Optional Feature:
- Macro: M_CAPTURE_AUTO_TRIG_EN.
- When defined:
  - Adds input auto_tmo [TIMEOUT_W-1:0].
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - When the counter equals auto_tmo (nonzero) with no trigger, the block takes a forced trigger at that cycle.
  - auto_tmo=0 disables the function.
  - Adds output auto_fired (1 bit), set on an auto trigger and cleared on the arm rising edge; reset value 0.
- When not defined: no port, no counter; WAIT lasts until a real trigger, force, or abort.

Test Plan:
- Reset, then arm with pre_len=4, post_len=3, ADDR_W=4, edge_sel=0; trig_pos at the 2nd WAIT cycle -> 4 PRE writes at addresses 0..3, trig_addr=5, writes to addresses 6..8, done=1 after the write to 8, wr_en=0 afterwards.
- Wrap: wr_addr starts at 14 (from a previous capture), pre_len=3, post_len=2 -> addresses 14,15,0 in PRE; after an immediate trigger, trig_addr=1, then writes to 2,3.
- edge_sel=1: trig_pos pulses ignored in WAIT; trig_neg pulse -> capture; trig_pos pulse in PRE ignored.
- Edge cases: pre_len=0 and post_len=0, force in the first WAIT cycle -> exactly one write, done one cycle later; arm held high in DONE -> no restart; arm low -> IDLE; re-arm -> new capture.
- Abort: arm dropped in the 2nd POST cycle -> IDLE, busy=0, done never asserted; async rst asserted mid-WAIT -> all outputs reset without waiting for a clock edge.
- M_CAPTURE_AUTO_TRIG_EN: auto_tmo=5, no trigger -> trigger taken on the 6th WAIT cycle and auto_fired=1; auto_tmo=0 -> WAIT held for 100 cycles with no trigger.
